// File: rtl/paint_engine.sv
// Brush rasteriser: command FIFO feeding a stamp/clear scanner that drives a stallable pixel write port.
// Define CIRCLE_BRUSH_EN for a round brush (pixels outside the disc are skipped); default is a square brush.
module paint_engine #(
  parameter int unsigned X_BITS      = 8,
  parameter int unsigned Y_BITS      = 8,
  parameter int unsigned COLOR_BITS  = 3,
  parameter int unsigned RADIUS_BITS = 2,
  parameter int unsigned CANVAS_W    = 160,
  parameter int unsigned CANVAS_H    = 120,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [X_BITS-1:0]      cmd_x,
  input  logic [Y_BITS-1:0]      cmd_y,
  input  logic [COLOR_BITS-1:0]  cmd_color,
  input  logic [RADIUS_BITS-1:0] cmd_radius,
  input  logic                   cmd_clear,
  output logic                   wr_en,
  input  logic                   wr_ready,
  output logic [X_BITS-1:0]      wr_x,
  output logic [Y_BITS-1:0]      wr_y,
  output logic [COLOR_BITS-1:0]  wr_color,
  output logic                   busy
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned D_W   = RADIUS_BITS + 1;
  localparam int unsigned CMD_W = 1 + X_BITS + Y_BITS + COLOR_BITS + RADIUS_BITS;
  localparam logic [PTR_W:0]            DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [X_BITS-1:0]         X_LAST  = X_BITS'(CANVAS_W - 1);
  localparam logic [Y_BITS-1:0]         Y_LAST  = Y_BITS'(CANVAS_H - 1);
  localparam logic signed [X_BITS+1:0]  W_S     = (X_BITS + 2)'(CANVAS_W);
  localparam logic signed [Y_BITS+1:0]  H_S     = (Y_BITS + 2)'(CANVAS_H);

  typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_e;
  state_e state_q, state_d;

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop, empty, full;

  logic                   h_clear;
  logic [X_BITS-1:0]      h_x;
  logic [Y_BITS-1:0]      h_y;
  logic [COLOR_BITS-1:0]  h_color;
  logic [RADIUS_BITS-1:0] h_r;

  logic [X_BITS-1:0]       cx_q, cx_d;
  logic [Y_BITS-1:0]       cy_q, cy_d;
  logic [COLOR_BITS-1:0]   color_q, color_d;
  logic [RADIUS_BITS-1:0]  r_q, r_d;
  logic signed [D_W-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic signed [D_W-1:0]   r_s, neg_q, neg_h;
  logic                    wr_en_q, wr_en_d;
  logic [X_BITS-1:0]       wr_x_q, wr_x_d;
  logic [Y_BITS-1:0]       wr_y_q, wr_y_d;
  logic [COLOR_BITS-1:0]   wr_color_q, wr_color_d;
  logic                    pix_adv, stamp_last, clear_last, load_pix, in_disk;
  logic signed [X_BITS+1:0] tx;
  logic signed [Y_BITS+1:0] ty;
`ifdef CIRCLE_BRUSH_EN
  logic signed [2*D_W:0] dxe, dye, re;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign {h_clear, h_x, h_y, h_color, h_r} = mem_q[rd_ptr_q];

  assign r_s        = $signed({1'b0, r_q});
  assign neg_q      = -r_s;
  assign neg_h      = -$signed({1'b0, h_r});
  // A clipped pixel (wr_en low) still consumes one cycle, so it advances unconditionally.
  assign pix_adv    = !wr_en_q || wr_ready;
  assign stamp_last = (dx_q == r_s) && (dy_q == r_s);
  assign clear_last = (wr_x_q == X_LAST) && (wr_y_q == Y_LAST);

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = h_clear ? CLEAR : STAMP;
      STAMP:   if (pix_adv && stamp_last) state_d = IDLE;
      CLEAR:   if (wr_ready && clear_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The write registers always hold the pixel currently presented; load_pix loads the next stamp pixel.
  always_comb begin
    cx_d = cx_q; cy_d = cy_q; color_d = color_q; r_d = r_q;
    dx_d = dx_q; dy_d = dy_q;
    wr_en_d = wr_en_q; wr_x_d = wr_x_q; wr_y_d = wr_y_q; wr_color_d = wr_color_q;
    load_pix = 1'b0;
    tx = '0;
    ty = '0;
    in_disk = 1'b1;
`ifdef CIRCLE_BRUSH_EN
    dxe = '0; dye = '0; re = '0;
`endif
    case (state_q)
      IDLE: if (!empty) begin
        if (h_clear) begin
          wr_en_d = 1'b1; wr_x_d = '0; wr_y_d = '0; wr_color_d = '0;
        end else begin
          cx_d = h_x; cy_d = h_y; color_d = h_color; r_d = h_r;
          dx_d = neg_h; dy_d = neg_h;
          load_pix = 1'b1;
        end
      end
      STAMP: if (pix_adv) begin
        if (stamp_last) begin
          wr_en_d = 1'b0;
        end else begin
          if (dx_q == r_s) begin
            dx_d = neg_q;
            dy_d = dy_q + D_W'(1);
          end else begin
            dx_d = dx_q + D_W'(1);
          end
          load_pix = 1'b1;
        end
      end
      CLEAR: if (wr_ready) begin
        if (clear_last) begin
          wr_en_d = 1'b0;
        end else if (wr_x_q == X_LAST) begin
          wr_x_d = '0;
          wr_y_d = wr_y_q + 1'b1;
        end else begin
          wr_x_d = wr_x_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (load_pix) begin
      tx = $signed({2'b00, cx_d}) + (X_BITS + 2)'(dx_d);
      ty = $signed({2'b00, cy_d}) + (Y_BITS + 2)'(dy_d);
`ifdef CIRCLE_BRUSH_EN
      dxe = (2*D_W + 1)'(dx_d);
      dye = (2*D_W + 1)'(dy_d);
      re  = $signed((2*D_W + 1)'(r_d));
      in_disk = (dxe*dxe + dye*dye) <= (re*re + re);
`endif
      wr_en_d    = !tx[X_BITS+1] && (tx < W_S) && !ty[Y_BITS+1] && (ty < H_S) && in_disk;
      wr_x_d     = tx[X_BITS-1:0];
      wr_y_d     = ty[Y_BITS-1:0];
      wr_color_d = color_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_clear, cmd_x, cmd_y, cmd_color, cmd_radius};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rd_ptr_q <= '0; wr_ptr_q <= '0; count_q <= '0;
      cx_q <= '0; cy_q <= '0; color_q <= '0; r_q <= '0;
      dx_q <= '0; dy_q <= '0;
      wr_en_q <= 1'b0; wr_x_q <= '0; wr_y_q <= '0; wr_color_q <= '0;
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d; wr_ptr_q <= wr_ptr_d; count_q <= count_d;
      cx_q <= cx_d; cy_q <= cy_d; color_q <= color_d; r_q <= r_d;
      dx_q <= dx_d; dy_q <= dy_d;
      wr_en_q <= wr_en_d; wr_x_q <= wr_x_d; wr_y_q <= wr_y_d; wr_color_q <= wr_color_d;
    end
  end

  assign cmd_ready = !full;
  assign busy      = (state_q != IDLE) || !empty;
  assign wr_en     = wr_en_q;
  assign wr_x      = wr_x_q;
  assign wr_y      = wr_y_q;
  assign wr_color  = wr_color_q;
endmodule

// File: tb/tb_paint_engine.sv
// Scoreboard bench for paint_engine: expected pixel writes are queued at command push and
// compared against every presented write (stalled or accepted).
module tb_paint_engine;
  localparam int XB = 8, YB = 8, CB = 3, RB = 2, CW = 160, CH = 120, FD = 4;
`ifdef CIRCLE_BRUSH_EN
  localparam int CORNER_R2_WR = 8;
  localparam int MID_R2_WR    = 21;
`else
  localparam int CORNER_R2_WR = 9;
  localparam int MID_R2_WR    = 25;
`endif

  logic          clk = 1'b0;
  logic          reset, cmd_valid, cmd_ready, cmd_clear;
  logic [XB-1:0] cmd_x, wr_x;
  logic [YB-1:0] cmd_y, wr_y;
  logic [CB-1:0] cmd_color, wr_color;
  logic [RB-1:0] cmd_radius;
  logic          wr_en, wr_ready, busy;

  always #5 clk = ~clk;

  paint_engine #(
    .X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB), .RADIUS_BITS(RB),
    .CANVAS_W(CW), .CANVAS_H(CH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .cmd_radius(cmd_radius), .cmd_clear(cmd_clear),
    .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .busy(busy)
  );

  typedef logic [XB+YB+CB-1:0] pix_t;
  pix_t exp_q[$];
  int n_vec = 0, n_miss = 0;
  int wr_cnt = 0, busy_cnt = 0, nowr_cnt = 0;
  int w0, b0, n0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs already final for the coming posedge.
  task automatic tick();
    if (reset) begin
      exp_q.delete();
    end else begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (wr_en !== 1'b1) nowr_cnt++;
      end
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_wr", 32'(wr_en), 32'd0);
        end else begin
          check_eq("wr_pix", 32'({wr_x, wr_y, wr_color}), 32'(exp_q[0]));
          if (wr_ready) begin
            void'(exp_q.pop_front());
            wr_cnt++;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic model_push(input int x, input int y, input int c, input int r, input bit clr);
    if (clr) begin
      for (int unsigned yy = 0; yy < CH; yy++)
        for (int unsigned xx = 0; xx < CW; xx++)
          exp_q.push_back({XB'(xx), YB'(yy), CB'(0)});
    end else begin
      for (int dy = -r; dy <= r; dy++) begin
        for (int dx = -r; dx <= r; dx++) begin
          int tx, ty;
          bit ok;
          tx = x + dx;
          ty = y + dy;
          ok = (tx >= 0) && (tx < CW) && (ty >= 0) && (ty < CH);
`ifdef CIRCLE_BRUSH_EN
          if (dx*dx + dy*dy > r*r + r) ok = 1'b0;
`endif
          if (ok) exp_q.push_back({XB'(tx), YB'(ty), CB'(c)});
        end
      end
    end
  endtask

  task automatic push_cmd(input int x, input int y, input int c, input int r, input bit clr);
    int unsigned w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (cmd_ready !== 1'b1) check_eq("push_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_x = XB'(x); cmd_y = YB'(y); cmd_color = CB'(c); cmd_radius = RB'(r);
    cmd_clear = clr; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    model_push(x, y, c, r, clr);
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned i = 0;
    while (busy !== 1'b0 && i < budget) begin
      tick();
      i++;
    end
    if (busy !== 1'b0) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic snap();
    w0 = wr_cnt; b0 = busy_cnt; n0 = nowr_cnt;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; wr_ready = 1'b1;
    cmd_x = '0; cmd_y = '0; cmd_color = '0; cmd_radius = '0;
    @(negedge clk);
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_x", 32'(wr_x), 32'd0);
    check_eq("rst_wr_y", 32'(wr_y), 32'd0);
    check_eq("rst_wr_color", 32'(wr_color), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Stamp (50,40) r=1: pop one edge after push, first write the cycle after that.
    push_cmd(50, 40, 5, 1, 1'b0);
    snap();
    check_eq("lat_wr_en_pre", 32'(wr_en), 32'd0);
    check_eq("lat_busy", 32'(busy), 32'd1);
    tick();
    check_eq("lat_wr_en", 32'(wr_en), 32'd1);
    check_eq("lat_first_pix", 32'({wr_x, wr_y, wr_color}), 32'({8'd49, 8'd39, 3'd5}));
    wait_idle(100);
    check_eq("s1_writes", 32'(wr_cnt - w0), 32'd9);
    check_eq("s1_busy_cycles", 32'(busy_cnt - b0), 32'd10);
    check_eq("s1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Corner stamp (0,0) r=2: 25 scan cycles plus the queued cycle before the pop.
    push_cmd(0, 0, 3, 2, 1'b0);
    snap();
    wait_idle(100);
    check_eq("s2_writes", 32'(wr_cnt - w0), 32'(CORNER_R2_WR));
    check_eq("s2_busy_cycles", 32'(busy_cnt - b0), 32'd26);
    check_eq("s2_idle_wr_cycles", 32'(nowr_cnt - n0), 32'(26 - CORNER_R2_WR));
    check_eq("s2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Far corner with wr_ready toggling every cycle.
    push_cmd(159, 119, 6, 1, 1'b0);
    snap();
    for (int unsigned i = 0; i < 100 && busy !== 1'b0; i++) begin
      wr_ready = ~wr_ready;
      tick();
    end
    wr_ready = 1'b1;
    wait_idle(20);
    check_eq("s3_writes", 32'(wr_cnt - w0), 32'd4);
    check_eq("s3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Fill the FIFO behind a stalled stamp, then drain in order.
    wr_ready = 1'b0;
    snap();
    for (int unsigned k = 0; k < 5; k++)
      push_cmd(int'(10 + 3*k), int'(20 + k), int'(k + 1), 0, 1'b0);
    check_eq("fifo_full_ready", 32'(cmd_ready), 32'd0);
    check_eq("fifo_full_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    check_eq("fifo_stall_ready", 32'(cmd_ready), 32'd0);
    wr_ready = 1'b1;
    tick();
    check_eq("fifo_ready_before_pop", 32'(cmd_ready), 32'd0);
    tick();
    check_eq("fifo_ready_after_pop", 32'(cmd_ready), 32'd1);
    wait_idle(100);
    check_eq("fifo_writes", 32'(wr_cnt - w0), 32'd5);
    check_eq("fifo_sb_empty", 32'(exp_q.size()), 32'd0);

    // Full canvas clear.
    push_cmd(77, 88, 7, 3, 1'b1);
    snap();
    wait_idle(20000);
    check_eq("clr_writes", 32'(wr_cnt - w0), 32'(CW * CH));
    check_eq("clr_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during a clear.
    push_cmd(0, 0, 0, 0, 1'b1);
    snap();
    for (int unsigned i = 0; i < 400 && (wr_cnt - w0) < 100; i++) tick();
    check_eq("clr_reached_100", 32'(wr_cnt - w0), 32'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("mid_rst_wr_xy", 32'({wr_x, wr_y}), 32'd0);
    repeat (4) tick();
    check_eq("post_rst_wr_en", 32'(wr_en), 32'd0);

    // Interior r=2 stamp: square brush writes all 25, round brush skips the 4 corners.
    push_cmd(10, 10, 2, 2, 1'b0);
    snap();
    wait_idle(100);
    check_eq("r2_writes", 32'(wr_cnt - w0), 32'(MID_R2_WR));
    check_eq("r2_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
